// File: rtl/txt_page_arb.sv
// Text-page owner: one single-port 1 KiB RAM shared by video fetch, CPU bus and a page-clear engine.
// Latency: video txt_q 2 cycles after txt_adr changes; CPU ack 2 cycles after its slot (1 if out of range).
// Backpressure: video has priority, CPU holds cpu_req until cpu_ack (forced slot after MAX_WAIT), clear stalls CPU.
module txt_page_arb #(
    parameter logic [15:0] BASE     = 16'h0400,
    parameter logic [7:0]  FILL     = 8'hA0,
    parameter int          MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] txt_adr,
    output logic [7:0]  txt_q,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_ack,
    input  logic        clr,
    output logic        busy
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] W_ONE = WW'(1);

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_busy;

    logic [7:0]    r_mem [0:1023];
    logic [7:0]    r_ram_q;
    logic          w_ram_we;
    logic [9:0]    w_ram_idx;
    logic [7:0]    w_ram_d;

    logic [9:0]    r_idx;
    logic [WW-1:0] r_wait;

    logic          r_c1;
    logic          r_c1_we;
    logic [9:0]    r_c1_idx;
    logic [7:0]    r_c1_d;
    logic [7:0]    r_cpu_q;
    logic          r_cpu_ack;

    logic          r_vpend;
    logic [15:0]   r_vadr_p;
    logic [15:0]   r_last_vadr;
    logic          r_vid_valid;
    logic [7:0]    r_txt_q;

    logic          w_run;
    logic          w_clr_go;
    logic          w_open;
    logic          w_vid_want;
    logic          w_cpu_free;
    logic          w_cpu_in;
    logic          w_cpu_oor;
    logic          w_cpu_slot;
    logic          w_vid_slot;
    logic          w_snoop;

    // Slot arbitration. A fetch already in flight for the current txt_adr suppresses a duplicate request.
    assign w_run      = (r_state == ST_RUN);
    assign w_clr_go   = w_run && clr;
    assign w_open     = w_run && !clr;
    assign w_vid_want = !(r_vpend && (r_vadr_p == txt_adr)) &&
                        ((txt_adr != r_last_vadr) || !r_vid_valid);
    assign w_cpu_free = cpu_req && !r_c1 && !r_cpu_ack;
    assign w_cpu_in   = (cpu_adr[15:10] == BASE[15:10]);
    assign w_cpu_oor  = w_open && w_cpu_free && !w_cpu_in;
    assign w_cpu_slot = w_open && w_cpu_free && w_cpu_in && (!w_vid_want || (r_wait == W_MAX));
    assign w_vid_slot = w_open && w_vid_want && !w_cpu_slot;
    assign w_snoop    = r_c1 && r_c1_we && r_vid_valid &&
                        (r_last_vadr[15:10] == BASE[15:10]) && (r_c1_idx == r_last_vadr[9:0]);

    // FSM next state: RUN -> CLEAR on clr, CLEAR -> RUN after the last index.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (clr) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (r_idx == 10'd1023) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (res) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Clear index: advances once per CLEAR cycle and wraps back to 0 after 1023.
    always_ff @(posedge clk) begin
        if (res)                       r_idx <= 10'd0;
        else if (r_state == ST_CLEAR)  r_idx <= r_idx + 10'd1;
    end

    // RAM port mux: clear engine owns the port outright, otherwise CPU slot, otherwise video read.
    always_comb begin
        w_ram_we  = 1'b0;
        w_ram_idx = txt_adr[9:0];
        w_ram_d   = cpu_d;
        if (r_state == ST_CLEAR) begin
            w_ram_we  = 1'b1;
            w_ram_idx = r_idx;
            w_ram_d   = FILL;
        end else if (w_cpu_slot) begin
            w_ram_we  = cpu_we;
            w_ram_idx = cpu_adr[9:0];
        end
    end

    // Single-port RAM, read-first; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_mem[w_ram_idx] <= w_ram_d;
        r_ram_q <= r_mem[w_ram_idx];
    end

    // CPU pipeline: slot -> RAM op -> ack; out-of-range requests ack directly with zero data.
    always_ff @(posedge clk) begin
        if (res) begin
            r_c1      <= 1'b0;
            r_c1_we   <= 1'b0;
            r_c1_idx  <= 10'd0;
            r_c1_d    <= 8'h00;
            r_cpu_ack <= 1'b0;
            r_cpu_q   <= 8'h00;
            r_wait    <= '0;
        end else begin
            r_c1      <= w_cpu_slot;
            r_cpu_ack <= r_c1 || w_cpu_oor;
            if (w_cpu_slot) begin
                r_c1_we  <= cpu_we;
                r_c1_idx <= cpu_adr[9:0];
                r_c1_d   <= cpu_d;
            end
            if (w_cpu_oor)              r_cpu_q <= 8'h00;
            else if (r_c1 && !r_c1_we)  r_cpu_q <= r_ram_q;
            if (w_cpu_slot || w_cpu_oor)          r_wait <= '0;
            else if (w_cpu_free && r_wait != W_MAX) r_wait <= r_wait + W_ONE;
        end
    end

    // Video pipeline and character cache, with clear override and CPU-write snoop.
    always_ff @(posedge clk) begin
        if (res) begin
            r_vpend     <= 1'b0;
            r_vadr_p    <= 16'h0000;
            r_last_vadr <= 16'h0000;
            r_vid_valid <= 1'b0;
            r_txt_q     <= 8'h00;
        end else begin
            r_vpend <= w_vid_slot;
            if (w_vid_slot) r_vadr_p <= txt_adr;
            if (w_clr_go) begin
                r_txt_q     <= FILL;
                r_vid_valid <= 1'b0;
            end else if (r_vpend) begin
                r_txt_q     <= (r_vadr_p[15:10] == BASE[15:10]) ? r_ram_q : 8'h00;
                r_last_vadr <= r_vadr_p;
                r_vid_valid <= 1'b1;
            end else if (w_snoop) begin
                r_txt_q <= r_c1_d;
            end
        end
    end

    assign txt_q   = r_txt_q;
    assign cpu_q   = r_cpu_q;
    assign cpu_ack = r_cpu_ack;
    assign busy    = w_busy;

endmodule

// File: tb/tb_txt_page_arb.sv
// Directed bench for txt_page_arb: CPU results queued at issue, compared at ack.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: CPU request held until ack, every wait bounded by a cycle budget.
module tb_txt_page_arb;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        res;
    logic [15:0] txt_adr;
    logic [7:0]  txt_q;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_ack;
    logic        clr;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [8:0] sb[$];   // {is_read, expected cpu_q}

    always #5 clk = ~clk;

    txt_page_arb #(
        .BASE(16'h0400), .FILL(8'hA0), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .res(res), .txt_adr(txt_adr), .txt_q(txt_q),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack), .clr(clr), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_start(input logic we, input logic [15:0] adr, input logic [7:0] d,
                             input logic [7:0] expq);
        cpu_we  = we;
        cpu_adr = adr;
        cpu_d   = d;
        cpu_req = 1'b1;
        sb.push_back({~we, expq});
    endtask

    task automatic cpu_finish(input string tag, input int lo, input int hi, input bit spin);
        int   n   = 0;
        bit   got = 1'b0;
        logic [8:0] e;
        if (spin) txt_adr = 16'h0600;
        while (!got && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (cpu_ack === 1'b1) got = 1'b1;
            else if (spin) txt_adr = 16'h0600 + 16'(n * 3);
        end
        cpu_req = 1'b0;
        check({tag, " ack_seen"}, 32'(got), 32'd1);
        check({tag, " latency_in_range"}, 32'(n >= lo && n <= hi), 32'd1);
        check({tag, " scoreboard_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e[8]) check({tag, " cpu_q"}, 32'(cpu_q), 32'(e[7:0]));
        end
    endtask

    task automatic cpu_txn(input string tag, input logic we, input logic [15:0] adr,
                           input logic [7:0] d, input logic [7:0] expq,
                           input int lo, input int hi, input bit spin);
        cpu_start(we, adr, d, expq);
        cpu_finish(tag, lo, hi, spin);
    endtask

    initial begin
        int  cnt;
        bit  ack_seen;

        res = 1'b1; txt_adr = 16'h0400; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_adr = 16'h0000; cpu_d = 8'h00; clr = 1'b0;
        step(3);
        check("reset txt_q", 32'(txt_q), 32'h00);
        check("reset cpu_ack", 32'(cpu_ack), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // Preload $400 through the CPU port, then reset and watch the fetch.
        res = 1'b0;
        step(3);
        cpu_txn("wr400", 1'b1, 16'h0400, 8'hC1, 8'h00, 2, 2, 1'b0);
        step(2);
        res = 1'b1;
        step(2);
        check("reset2 txt_q", 32'(txt_q), 32'h00);
        res = 1'b0;
        step(2);
        check("t1 txt_q by cycle 2", 32'(txt_q), 32'hC1);
        check("t1 cpu_ack", 32'(cpu_ack), 32'd0);
        check("t1 busy", 32'(busy), 32'd0);
        step(1);

        // CPU write then read with static video address.
        cpu_txn("wr450", 1'b1, 16'h0450, 8'h41, 8'h00, 2, 2, 1'b0);
        step(1);
        cpu_txn("rd450", 1'b0, 16'h0450, 8'h00, 8'h41, 2, 2, 1'b0);
        step(1);

        // Video address changing every cycle: starvation guard forces a CPU slot.
        cpu_txn("rd450 spin", 1'b0, 16'h0450, 8'h00, 8'h41, 2, MAX_WAIT + 2, 1'b1);
        txt_adr = 16'h0450;
        step(3);
        check("t3 txt_q after spin", 32'(txt_q), 32'h41);

        // Snoop: write to the displayed character updates txt_q in the ack cycle.
        txt_adr = 16'h05A8;
        step(3);
        cpu_txn("wr5a8 snoop", 1'b1, 16'h05A8, 8'h55, 8'h00, 2, 2, 1'b0);
        check("t4 txt_q at ack", 32'(txt_q), 32'h55);
        step(3);
        check("t4 txt_q held", 32'(txt_q), 32'h55);

        // Page clear with a CPU read pending and a stray clr pulse mid-clear.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("t5 busy first cycle", 32'(busy), 32'd1);
        check("t5 txt_q fill first cycle", 32'(txt_q), 32'hA0);
        cpu_start(1'b0, 16'h0450, 8'h00, 8'hA0);
        cnt = 0;
        ack_seen = 1'b0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            clr = (cnt == 300);
            step(1);
            if (cpu_ack === 1'b1) ack_seen = 1'b1;
        end
        clr = 1'b0;
        check("t5 busy cycles", 32'(cnt), 32'd1024);
        check("t5 no ack while busy", 32'(ack_seen), 32'd0);
        cpu_finish("rd450 after clear", 2, MAX_WAIT + 2, 1'b0);
        step(1);
        cpu_txn("rd400 cleared", 1'b0, 16'h0400, 8'h00, 8'hA0, 2, 3, 1'b0);
        step(1);
        cpu_txn("rd7ff cleared", 1'b0, 16'h07FF, 8'h00, 8'hA0, 2, 2, 1'b0);
        check("t5 txt_q refetch", 32'(txt_q), 32'hA0);

        // Out-of-range CPU accesses.
        step(1);
        cpu_txn("rd0300 oor", 1'b0, 16'h0300, 8'h00, 8'h00, 1, 1, 1'b0);
        step(1);
        cpu_txn("wr0800 oor", 1'b1, 16'h0800, 8'h5A, 8'h00, 1, 1, 1'b0);
        step(1);
        cpu_txn("rd400 unchanged", 1'b0, 16'h0400, 8'h00, 8'hA0, 2, 2, 1'b0);

        // Reset in the middle of a clear: partial contents remain.
        step(1);
        cpu_txn("wr7f0", 1'b1, 16'h07F0, 8'h3C, 8'h00, 2, 2, 1'b0);
        step(1);
        cpu_txn("wr401", 1'b1, 16'h0401, 8'h77, 8'h00, 2, 2, 1'b0);
        step(1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(499);
        check("t6 busy before reset", 32'(busy), 32'd1);
        res = 1'b1;
        step(1);
        check("t6 busy after reset", 32'(busy), 32'd0);
        check("t6 cpu_ack after reset", 32'(cpu_ack), 32'd0);
        check("t6 txt_q after reset", 32'(txt_q), 32'h00);
        res = 1'b0;
        step(3);
        cpu_txn("rd7f0 uncleared", 1'b0, 16'h07F0, 8'h00, 8'h3C, 2, 2, 1'b0);
        step(1);
        cpu_txn("rd401 cleared", 1'b0, 16'h0401, 8'h00, 8'hA0, 2, 2, 1'b0);
        check("t6 busy stays low", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
